instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 The block SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-006 The block SHALL have port imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-007 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 The block SHALL have port stall  input  1  downstream cannot accept a new instruction.
REQ-009 The block SHALL have port branch_taken  input  1  redirect request; this is the control unit's Branch output ANDed with the ALU zero flag.
REQ-010 The block SHALL have port branch_target  input  32  redirect address.
REQ-011 The block SHALL have port instr  output  32  registered instruction.
REQ-012 The block SHALL have port opCode  output  6  instr[31:26], which feeds the control unit.
REQ-013 The block SHALL have port pc_plus4  output  32  address of instr plus 4.
REQ-014 The block SHALL have port instr_valid  output  1  instr, opCode and pc_plus4 are meaningful.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, FETCH and HOLD.
REQ-016 The FSM SHALL go from IDLE to FETCH on the first clock edge after reset deasserts.
REQ-017 imem_req SHALL be 1 only in FETCH, and imem_addr SHALL equal pc at all times.
REQ-018 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-019 On FETCH with imem_ready=1 and branch_taken=0: instr<=imem_rdata, pc_plus4<=pc+4, pc<=pc+4, and instr_valid<=1, all on the next edge.
REQ-020 Fetch latency SHALL be 1 cycle from the accepting edge to instr_valid; throughput SHALL be one instruction per cycle when imem_ready is held high.
REQ-021 FETCH SHALL go to HOLD when instr_valid=1 and stall=1; in HOLD, imem_req=0 and instr, opCode, pc_plus4 and instr_valid hold their values.
REQ-022 HOLD SHALL return to FETCH on the first edge with stall=0.
REQ-023 A response (imem_ready=1) that coincides with stall=1 and instr_valid=1 SHALL NOT be accepted, and pc SHALL NOT advance.
REQ-024 branch_taken=1 in any non-IDLE state SHALL set pc<=branch_target with bits [1:0] forced to 0, clear instr_valid on the next edge, and move to FETCH.
REQ-025 When branch_taken=1, any imem_ready response in the same cycle SHALL be discarded.
REQ-026 branch_taken SHALL have priority over stall and over imem_ready.
REQ-027 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 opCode SHALL be combinational from the instr register.

Reset
REQ-029 While reset=1: pc=RESET_PC, state=IDLE, imem_req=0, instr=0, opCode=6'b000000, pc_plus4=0, instr_valid=0.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding fetch; a late imem_ready after reset deasserts but before FETCH SHALL be ignored.

Configuration
REQ-031 With macro INSTR_FETCH_PERF_EN defined, the block SHALL add outputs fetch_count[31:0] and stall_count[31:0]: fetch_count increments on each accepted fetch, stall_count increments each cycle in HOLD; both clear on reset and wrap at 2^32.
REQ-032 Without INSTR_FETCH_PERF_EN, those ports and counters SHALL NOT exist.

Structure
REQ-033 Shared package mips_pkg SHALL hold the fetch_state_t enum (IDLE/FETCH/HOLD), the opcode constants (R-format 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100) and the PC_INCR=4 constant.
REQ-034 The PC register and next-PC mux SHALL be a sub-module named pc_reg; the FSM and output register SHALL stay in instr_fetch.

Verification
REQ-035 Reset then release, with imem_ready=1 and rdata=32'h8C22_0004 -> imem_addr=0; the next cycle instr_valid=1, opCode=6'b100011, pc_plus4=4.
REQ-036 imem_ready=1 for 4 cycles with sequential lw/sw/beq/R words -> imem_addr goes 0,4,8,C; opCode goes 100011,101011,000100,000000 back-to-back.
REQ-037 Raise stall for 3 cycles while instr_valid=1 -> imem_req=0, instr is held, state is HOLD; one cycle after stall drops, imem_req=1 with the same imem_addr.
REQ-038 branch_taken=1, branch_target=32'h0000_0043, simultaneous with imem_ready and stall -> the response is dropped, the next imem_addr is 32'h0000_0040, and instr_valid=0 for one cycle.
REQ-039 RESET_PC=32'hFFFF_FFFC with one accepted fetch -> pc_plus4=0 and the next imem_addr is 0.
REQ-040 Assert reset while imem_req=1 and imem_ready=0 -> all outputs take their reset values immediately (asynchronously); with INSTR_FETCH_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage state type, MIPS opcode constants and PC step.
package mips_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
  localparam logic [5:0] OP_RFMT = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [31:0] PC_INCR = 32'd4;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with redirect/sequential next-pc mux.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_seq
);
  logic [31:0] pc_q, pc_d;
  assign pc_seq = pc_q + PC_INCR;
  assign pc = pc_q;
  // Redirect targets are forced word-aligned.
  always_comb pc_d = redirect ? (target & ~32'd3) : advance ? pc_seq : pc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IDLE/FETCH/HOLD fetch stage with registered instruction output.
// Optional INSTR_FETCH_PERF_EN adds fetch_count/stall_count counters.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [5:0]  opCode,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  fetch_state_t state_q, state_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d, pc, pc_seq;
  logic valid_q, valid_d, redirect, accept;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .advance(accept),
    .redirect(redirect),
    .target(branch_target),
    .pc(pc),
    .pc_seq(pc_seq)
  );
  // A response is refused while a valid instruction is stalled downstream.
  always_comb begin
    redirect = branch_taken && state_q != IDLE;
    accept = state_q == FETCH && imem_ready && !redirect && !(valid_q && stall);
    state_d = (state_q == IDLE || redirect) ? FETCH :
              (state_q == FETCH && valid_q && stall) ? HOLD :
              (state_q == HOLD && !stall) ? FETCH : state_q;
    instr_d = accept ? imem_rdata : instr_q;
    pc4_d = accept ? pc_seq : pc4_q;
    valid_d = redirect ? 1'b0 : accept ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      pc4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
    end
  assign imem_req = state_q == FETCH;
  assign imem_addr = pc;
  assign instr = instr_q;
  assign opCode = instr_q[31:26];
  assign pc_plus4 = pc4_q;
  assign instr_valid = valid_q;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fcnt_q, scnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      if (accept) fcnt_q <= fcnt_q + 32'd1;
      if (state_q == HOLD) scnt_q <= scnt_q + 32'd1;
    end
  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch (default and RESET_PC=FFFF_FFFC).
module tb_instr_fetch;
  import mips_pkg::*;
  logic clk = 1'b0, reset = 1'b1, imem_ready = 1'b0, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] imem_rdata = '0, branch_target = '0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_plus4;
  logic [5:0] opCode;
  logic r2 = 1'b1, req2, valid2;
  logic [31:0] addr2, instr2, pc4_2;
  logic [5:0] op2;
  int checks = 0, errors = 0;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count, fc2, sc2;
`endif
  always #5 clk = ~clk;
  instr_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .instr(instr),
    .opCode(opCode), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
`ifdef INSTR_FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(r2), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(1'b1), .imem_rdata(32'h8C22_0004), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0), .instr(instr2),
    .opCode(op2), .pc_plus4(pc4_2), .instr_valid(valid2)
`ifdef INSTR_FETCH_PERF_EN
    , .fetch_count(fc2), .stall_count(sc2)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, " req"}, 32'(imem_req), 32'd0);
    chk({tag, " addr"}, imem_addr, 32'h0);
    chk({tag, " instr"}, instr, 32'h0);
    chk({tag, " opCode"}, 32'(opCode), 32'd0);
    chk({tag, " pc_plus4"}, pc_plus4, 32'h0);
    chk({tag, " valid"}, 32'(instr_valid), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
    chk({tag, " fetch_count"}, fetch_count, 32'h0);
    chk({tag, " stall_count"}, stall_count, 32'h0);
`endif
  endtask
  initial begin
    step;
    chk_reset_vals("reset");
    chk("reset state", 32'(dut.state_q), 32'(IDLE));
    imem_ready = 1'b1;
    imem_rdata = 32'h8C22_0004;
    reset = 1'b0;
    step;
    chk("idle->fetch req", 32'(imem_req), 32'd1);
    chk("first addr", imem_addr, 32'h0);
    chk("first valid pre", 32'(instr_valid), 32'd0);
    step;
    chk("lw valid", 32'(instr_valid), 32'd1);
    chk("lw opCode", 32'(opCode), 32'(OP_LW));
    chk("lw instr", instr, 32'h8C22_0004);
    chk("lw pc_plus4", pc_plus4, 32'h4);
    chk("addr 4", imem_addr, 32'h4);
    imem_rdata = 32'hAC22_0008;
    step;
    chk("sw opCode", 32'(opCode), 32'(OP_SW));
    chk("addr 8", imem_addr, 32'h8);
    imem_rdata = 32'h1022_0003;
    step;
    chk("beq opCode", 32'(opCode), 32'(OP_BEQ));
    chk("addr C", imem_addr, 32'hC);
    imem_rdata = 32'h0022_1820;
    step;
    chk("rfmt opCode", 32'(opCode), 32'(OP_RFMT));
    chk("addr 10", imem_addr, 32'h10);
    chk("rfmt pc_plus4", pc_plus4, 32'h10);
    stall = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("hold req", 32'(imem_req), 32'd0);
      chk("hold instr", instr, 32'h0022_1820);
      chk("hold state", 32'(dut.state_q), 32'(HOLD));
      chk("hold addr", imem_addr, 32'h10);
    end
    stall = 1'b0;
    step;
    chk("resume req", 32'(imem_req), 32'd1);
    chk("resume addr", imem_addr, 32'h10);
    chk("resume instr", instr, 32'h0022_1820);
    chk("resume pc_plus4", pc_plus4, 32'h10);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0043;
    stall = 1'b1;
    imem_rdata = 32'h8C22_0004;
    step;
    chk("br addr", imem_addr, 32'h40);
    chk("br valid", 32'(instr_valid), 32'd0);
    chk("br instr dropped", instr, 32'h0022_1820);
    chk("br req", 32'(imem_req), 32'd1);
    branch_taken = 1'b0;
    stall = 1'b0;
    imem_rdata = 32'hAC22_0008;
    step;
    chk("post-br valid", 32'(instr_valid), 32'd1);
    chk("post-br instr", instr, 32'hAC22_0008);
    chk("post-br pc_plus4", pc_plus4, 32'h44);
    chk("post-br addr", imem_addr, 32'h44);
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step;
      chk("wait addr stable", imem_addr, 32'h44);
      chk("wait req", 32'(imem_req), 32'd1);
      chk("wait valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b1;
    step;
    chk("hold2 state", 32'(dut.state_q), 32'(HOLD));
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    step;
    chk("br-hold addr", imem_addr, 32'h100);
    chk("br-hold valid", 32'(instr_valid), 32'd0);
    chk("br-hold req", 32'(imem_req), 32'd1);
    branch_taken = 1'b0;
    stall = 1'b0;
    step;
    chk("pending req", 32'(imem_req), 32'd1);
    chk("pending addr", imem_addr, 32'h100);
    reset = 1'b1;
    #1;
    chk_reset_vals("async reset");
    step;
    chk_reset_vals("held reset");
    imem_ready = 1'b1;
    imem_rdata = 32'h8C22_0004;
    reset = 1'b0;
    step;
    chk("late ready ignored valid", 32'(instr_valid), 32'd0);
    chk("late ready ignored instr", instr, 32'h0);
    chk("restart addr", imem_addr, 32'h0);
    chk("restart req", 32'(imem_req), 32'd1);
    chk("wrap reset addr", addr2, 32'hFFFF_FFFC);
    r2 = 1'b0;
    step;
    chk("wrap fetch addr", addr2, 32'hFFFF_FFFC);
    chk("wrap req", 32'(req2), 32'd1);
    step;
    chk("wrap pc_plus4", pc4_2, 32'h0);
    chk("wrap next addr", addr2, 32'h0);
    chk("wrap valid", 32'(valid2), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
